// File: rtl/pattern_pkg.sv
// Shared constants and types for the pattern chain loader.
package pattern_pkg;

  // Chain geometry, shared with patternbuf.
  localparam int unsigned PATTERN_BYTES = 27;
  localparam int unsigned PATTERN_BW    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StShift
  } loader_state_t;

  // Counter width for a count of n items; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned LOADER_BITCNT_W  = cnt_width(PATTERN_BW);
  localparam int unsigned LOADER_BYTECNT_W = cnt_width(PATTERN_BYTES);

endpackage

// File: rtl/pattern_loader_if.sv
// Host byte stream, chain serial link and status for pattern_loader.
interface pattern_loader_if
  import pattern_pkg::*;
#(
  parameter int unsigned BW = PATTERN_BW
) ();

  logic          start;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          sin;
  logic          ssel;
  logic          sout;
  logic [BW-1:0] rb_data;
  logic          rb_valid;
  logic          busy;
  logic          done;

  // Host plus chain side.
  modport master (
    output start, in_data, in_valid, sout,
    input  in_ready, sin, ssel, rb_data, rb_valid, busy, done
  );

  // Loader side.
  modport slave (
    input  start, in_data, in_valid, sout,
    output in_ready, sin, ssel, rb_data, rb_valid, busy, done
  );

endinterface

// File: rtl/pattern_ser8.sv
// Byte serialiser: shifts one byte out MSB-first while collecting chain tail bits.
module pattern_ser8
  import pattern_pkg::*;
#(
  parameter int unsigned BW = PATTERN_BW
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          load,
  input  logic [BW-1:0] load_data,
  input  logic          shift,
  input  logic          sout,
  output logic          sin,
  output logic          last,
  output logic [BW-1:0] rb_byte
);

  localparam int unsigned CntW = cnt_width(BW);

  logic [BW-1:0]   shreg_q;
  logic [BW-2:0]   rbreg_q;
  logic [CntW-1:0] bitcnt_q;

  // Shift/load registers; a load on the last-bit edge takes priority for shreg and bitcnt.
  always_ff @(posedge sclk) begin
    if (rst) begin
      shreg_q  <= '0;
      rbreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      if (load) begin
        shreg_q <= load_data;
      end else if (shift) begin
        shreg_q <= {shreg_q[BW-2:0], 1'b0};
      end
      if (shift) begin
        rbreg_q <= rb_byte[BW-2:0];
      end
      if (load) begin
        bitcnt_q <= '0;
      end else if (shift && !last) begin
        bitcnt_q <= bitcnt_q + CntW'(1);
      end
    end
  end

  assign sin     = shreg_q[BW-1];
  assign last    = (bitcnt_q == CntW'(BW - 1));
  // Readback byte as it stands after the current edge's shift.
  assign rb_byte = {rbreg_q, sout};

endmodule

// File: rtl/pattern_loader.sv
// Loads one frame of NBYTES bytes into the pattern chain and reads back its old contents.
module pattern_loader
  import pattern_pkg::*;
#(
  parameter int unsigned NBYTES = PATTERN_BYTES,
  parameter int unsigned BW     = PATTERN_BW
) (
  input logic             sclk,
  input logic             rst,
  pattern_loader_if.slave bus
);

  localparam int unsigned ByteW = cnt_width(NBYTES);

  loader_state_t state_q, state_d;
  logic [ByteW-1:0] bytecnt_q, bytecnt_d;
  logic [BW-1:0]    rb_data_q, rb_data_d;
  logic             rb_valid_q, rb_valid_d;
  logic             done_q, done_d;
  logic             in_ready;
  logic             load;
  logic             shift;
  logic             ser_sin;
  logic             ser_last;
  logic [BW-1:0]    rb_byte;
  logic             last_byte;

  assign shift     = (state_q == StShift);
  assign last_byte = (bytecnt_q == ByteW'(NBYTES - 1));

  pattern_ser8 #(
    .BW(BW)
  ) u_ser (
    .sclk     (sclk),
    .rst      (rst),
    .load     (load),
    .load_data(bus.in_data),
    .shift    (shift),
    .sout     (bus.sout),
    .sin      (ser_sin),
    .last     (ser_last),
    .rb_byte  (rb_byte)
  );

  // State, byte counter and registered strobes.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= StIdle;
      bytecnt_q  <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bytecnt_q  <= bytecnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      done_q     <= done_d;
    end
  end

  // Next state, handshake and strobe generation.
  always_comb begin
    state_d    = state_q;
    bytecnt_d  = bytecnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StWait;
          bytecnt_d = '0;
        end
      end
      StWait: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (ser_last) begin
          rb_valid_d = 1'b1;
          rb_data_d  = rb_byte;
          if (last_byte) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            bytecnt_d = bytecnt_q + ByteW'(1);
            // Accepting here keeps the chain shifting without a bubble.
            in_ready  = 1'b1;
            if (bus.in_valid) begin
              load = 1'b1;
            end else begin
              state_d = StWait;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.ssel     = shift;
  assign bus.sin      = shift & ser_sin;
  assign bus.rb_data  = rb_data_q;
  assign bus.rb_valid = rb_valid_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader driving a behavioural pattern chain.
module tb_pattern_loader;
  import pattern_pkg::*;

  localparam int unsigned NB = PATTERN_BYTES;
  localparam int unsigned BW = PATTERN_BW;
  localparam int unsigned CW = NB * BW;

  logic sclk = 1'b0;
  logic rst  = 1'b1;

  pattern_loader_if #(.BW(BW)) bus ();

  pattern_loader #(
    .NBYTES(NB),
    .BW    (BW)
  ) dut (
    .sclk(sclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 sclk = ~sclk;

  // Behavioural chain: slot i occupies chain[i*BW +: BW]; tail is slot NB-1 MSB.
  logic [CW-1:0] chain   = '0;
  logic [CW-1:0] pre_val = '0;
  logic          preload = 1'b0;
  always @(posedge sclk) begin
    if (preload) chain <= pre_val;
    else if (bus.ssel) chain <= {chain[CW-2:0], bus.sin};
  end
  assign bus.sout = chain[CW-1];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor; cycle N is the period that ends at edge N, edge 0 being the start edge.
  time          t0 = 0;
  bit           mon_clr = 1'b0;
  int           ssel_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int           first_ssel = -1, last_ssel = -1, done_rel = -1, last_rb_rel = -1;
  logic [15:0]  sin_bits = '0;
  logic [7:0]   rb_q[$];
  bit           done_idle = 1'b0;

  always @(negedge sclk) begin
    int rel;
    rel = int'(($time - t0 + 5) / 10);
    if (mon_clr) begin
      ssel_cnt = 0; done_cnt = 0; acc_cnt = 0;
      first_ssel = -1; last_ssel = -1; done_rel = -1; last_rb_rel = -1;
      sin_bits = '0; done_idle = 1'b0;
      rb_q.delete();
    end else begin
      if (bus.ssel) begin
        if (ssel_cnt < 16) sin_bits = {sin_bits[14:0], bus.sin};
        if (ssel_cnt == 0) first_ssel = rel;
        last_ssel = rel;
        ssel_cnt++;
      end
      if (bus.rb_valid) begin
        rb_q.push_back(bus.rb_data);
        last_rb_rel = rel;
      end
      if (bus.done) begin
        done_cnt++;
        done_rel  = rel;
        done_idle = !bus.busy;
      end
      if (bus.in_valid && bus.in_ready) acc_cnt++;
    end
  end

  logic [7:0]    frame_b[NB];
  logic [CW-1:0] pre_pat, exp_pat;

  task automatic clear_mon();
    @(posedge sclk); #1 mon_clr = 1'b1;
    @(negedge sclk); #1 mon_clr = 1'b0;
  endtask

  task automatic do_preload(input logic [CW-1:0] v);
    pre_val = v;
    @(posedge sclk); #1 preload = 1'b1;
    @(posedge sclk); #1 preload = 1'b0;
  endtask

  // One frame from frame_b with in_valid held high, optional bubble, mid-frame start or abort.
  task automatic run_frame(input int gap_at, input int gap_len, input bit mid_start,
                           input int abort_at);
    int idx, gc, k;
    bit acc, aborted;
    logic [CW-1:0] snap;
    clear_mon();
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = frame_b[0];
    @(posedge sclk);
    t0 = $time;
    #1 bus.start = 1'b0;
    idx = 0; gc = 0; snap = '0; aborted = 1'b0;
    for (int n = 0; n < 400 && done_cnt == 0 && !aborted; n++) begin
      @(negedge sclk); #1;
      acc = bus.in_ready & bus.in_valid;
      if (gc > 0) begin
        k = BW + gap_len - gc;
        if (k == BW) snap = chain;
        if (k >= BW) begin
          check("bubble_ssel", bus.ssel, 0);
          check("bubble_ready", bus.in_ready, 1);
        end
        if (k > BW) check("bubble_chain_hold", chain, snap);
      end
      if (abort_at > 0 && ssel_cnt == abort_at) begin
        rst = 1'b1;
        aborted = 1'b1;
      end else begin
        @(posedge sclk); #1;
        if (mid_start) bus.start = (ssel_cnt == 50);
        if (acc) begin
          idx++;
          if (idx < NB) bus.in_data = frame_b[idx];
        end
        if (gc > 0) begin
          gc--;
          if (gc == 0) bus.in_valid = 1'b1;
        end else if (acc && idx == gap_at) begin
          gc = BW + gap_len;
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NB; i++) begin
      pre_pat[i*BW +: BW] = 8'(8'hA0 + i);
      exp_pat[i*BW +: BW] = 8'(NB - i);
    end

    // Reset held with start and in_valid asserted.
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    repeat (3) begin
      @(negedge sclk); #1;
      check("rst_outputs", {bus.in_ready, bus.sin, bus.ssel, bus.rb_data, bus.rb_valid,
                            bus.busy, bus.done}, 0);
    end
    rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
    @(negedge sclk); #1;
    check("post_rst_outputs", {bus.in_ready, bus.sin, bus.ssel, bus.rb_data, bus.rb_valid,
                               bus.busy, bus.done}, 0);
    check("rst_no_ssel", ssel_cnt, 0);

    // Gapless frame 0x01..0x1B into a chain holding 0xA0..0xBA.
    for (int i = 0; i < NB; i++) frame_b[i] = 8'(i + 1);
    do_preload(pre_pat);
    run_frame(-1, 0, 1'b0, 0);
    check("gl_chain", chain, exp_pat);
    check("gl_ssel_cnt", ssel_cnt, 216);
    check("gl_first_ssel", first_ssel, 2);
    check("gl_last_ssel", last_ssel, 217);
    check("gl_done_cycle", done_rel, 218);
    check("gl_done_cnt", done_cnt, 1);
    check("gl_done_idle", done_idle, 1);
    check("gl_last_rb_cycle", last_rb_rel, 218);
    check("gl_rb_count", rb_q.size(), NB);
    for (int k = 0; k < NB; k++) check($sformatf("gl_rb%0d", k), rb_q[k], 8'(8'hBA - k));

    // Bubble after byte 3, start pulsed mid-frame, in_valid left high afterwards.
    do_preload(pre_pat);
    run_frame(3, 5, 1'b1, 0);
    repeat (10) @(negedge sclk);
    #1;
    check("bb_chain", chain, exp_pat);
    check("bb_ssel_cnt", ssel_cnt, 216);
    check("bb_done_cycle", done_rel, 224);
    check("bb_rb0", rb_q[0], 8'hBA);
    check("bb_rb26", rb_q[26], 8'hA0);
    check("idle_accepts", acc_cnt, NB);
    check("idle_busy", bus.busy, 0);
    check("idle_ready", bus.in_ready, 0);
    check("idle_done_cnt", done_cnt, 1);

    // Reset during bit 4 of byte 10: 85 shifts land, then the chain stops.
    do_preload(pre_pat);
    run_frame(-1, 0, 1'b0, 85);
    @(negedge sclk); #1;
    check("abort_ssel", bus.ssel, 0);
    check("abort_busy", bus.busy, 0);
    rst = 1'b0; bus.in_valid = 1'b0;
    repeat (6) @(negedge sclk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_ssel_cnt", ssel_cnt, 85);
    check("abort_chain_hi", chain[CW-1:85], pre_pat[CW-86:0]);

    // Fresh frame after the abort.
    run_frame(-1, 0, 1'b0, 0);
    check("fresh_chain", chain, exp_pat);
    check("fresh_done_cycle", done_rel, 218);
    check("fresh_rb_count", rb_q.size(), NB);

    // Bit order: 0x80 then 0x01.
    for (int i = 0; i < NB; i++) frame_b[i] = 8'h55;
    frame_b[0] = 8'h80;
    frame_b[1] = 8'h01;
    run_frame(-1, 0, 1'b0, 0);
    check("sin_order", sin_bits, 16'h8001);
    check("sin_slot26", chain[CW-1 -: 8], 8'h80);
    check("sin_slot25", chain[CW-9 -: 8], 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
